// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
//
// Sequences one run of an attached core and reports how the run ended.
// A run goes through these states:
//   IDLE -> CRST  the core is held in reset for RST_CYCLES cycles
//        -> RUN   the core executes while cycles, retirements and stalls
//                 are counted
//        -> FIN   the result and the counters are held until the next START
//
// A run ends on a core error (STAT != 0), a halt or a timeout.
// A halt is the same PC retiring HALT_REPEAT times in a row.
// A timeout is CYCLES reaching TIMEOUT_CYCLES.
//
// Configuration macro:
//   RUN_CTRL_PERF_EN  build the STALLS counter. When it is undefined,
//                     STALLS is tied to 0 and STALL is ignored.
//
// Ports:
//   CLK        clock; all logic runs on the rising edge
//   RST        synchronous, active-high reset
//   START      request to begin a run; ignored while BUSY
//   STAT       core status; any nonzero value is a core error
//   RET_VALID  the core retired one instruction this cycle
//   RET_PC     PC of the retired instruction
//   STALL      the core pipeline stalled this cycle
//   CORE_RST   reset to the core
//   EXEC       execute enable to the core
//   BUSY       a run is in progress (CRST or RUN)
//   DONE       the run has finished and RESULT is valid
//   RESULT     00 none, 01 halt, 10 timeout, 11 error
//   CYCLES     number of cycles spent in RUN
//   INSTRET    number of retired instructions
//   STALLS     number of stalled RUN cycles
// ---------------------------------------------------------------------------
module core_run_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4500,
    parameter int RST_CYCLES     = 10,
    parameter int HALT_REPEAT    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [7:0]       STAT,
    input  logic             RET_VALID,
    input  logic [31:0]      RET_PC,
    input  logic             STALL,
    output logic             CORE_RST,
    output logic             EXEC,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       RESULT,
    output logic [CNT_W-1:0] CYCLES,
    output logic [CNT_W-1:0] INSTRET,
    output logic [CNT_W-1:0] STALLS
);

    typedef enum logic [1:0] {IDLE, CRST, RUN, FIN} state_t;
    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_HALT    = 2'b01,
        RES_TIMEOUT = 2'b10,
        RES_ERROR   = 2'b11
    } result_t;

    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int REP_W = $clog2(HALT_REPEAT + 1);
    localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(RST_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_HALT    = REP_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state, state_next;
    result_t          result, result_next;
    logic [RC_W-1:0]  rc_cnt;
    logic [REP_W-1:0] rep_cnt, rep_next;
    logic [31:0]      last_pc;
    logic             start_run;
    logic             pc_repeat;
    logic [CNT_W-1:0] cycles_inc;

    // A retirement is a repeat only if some earlier retirement in this run
    // set last_pc. rep_cnt == 0 means nothing has retired yet, so the first
    // retirement never matches the cleared last_pc, even when its PC is 0.
    assign pc_repeat  = RET_VALID && (rep_cnt != '0) && (RET_PC == last_pc);
    assign rep_next   = pc_repeat ? rep_cnt + REP_W'(1) : REP_W'(1);
    assign cycles_inc = sat_inc(CYCLES);

    // NOTE: every signal written here gets a default first. Any path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        state_next  = state;
        result_next = result;
        start_run   = 1'b0;
        CORE_RST    = 1'b0;
        EXEC        = 1'b0;
        BUSY        = 1'b0;
        DONE        = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next  = CRST;
                    result_next = RES_NONE;
                    start_run   = 1'b1;
                end
            end
            CRST: begin
                CORE_RST = 1'b1;
                BUSY     = 1'b1;
                if (rc_cnt == RC_LAST) state_next = RUN;
            end
            RUN: begin
                EXEC = 1'b1;
                BUSY = 1'b1;
                // Check order gives the priority: error, then halt, then timeout.
                if (STAT != 8'h00) begin
                    state_next  = FIN;
                    result_next = RES_ERROR;
                end else if (RET_VALID && (rep_next >= REP_HALT)) begin
                    state_next  = FIN;
                    result_next = RES_HALT;
                end else if (cycles_inc >= TIMEOUT_VAL) begin
                    state_next  = FIN;
                    result_next = RES_TIMEOUT;
                end
            end
            FIN: begin
                DONE = 1'b1;
                if (START) begin
                    state_next  = CRST;
                    result_next = RES_NONE;
                    start_run   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign RESULT = result;

    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together from the values they had before the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            result <= RES_NONE;
        end else begin
            state  <= state_next;
            result <= result_next;
        end
    end

    // Run counters. They are written only in RUN, so they freeze in FIN
    // and keep the exit cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rc_cnt  <= '0;
            rep_cnt <= '0;
            last_pc <= '0;
            CYCLES  <= '0;
            INSTRET <= '0;
        end else if (start_run) begin
            rc_cnt  <= '0;
            rep_cnt <= '0;
            last_pc <= '0;
            CYCLES  <= '0;
            INSTRET <= '0;
        end else if (state == CRST) begin
            rc_cnt <= rc_cnt + RC_W'(1);
        end else if (state == RUN) begin
            CYCLES <= cycles_inc;
            if (RET_VALID) begin
                INSTRET <= sat_inc(INSTRET);
                rep_cnt <= rep_next;
                if (!pc_repeat) last_pc <= RET_PC;
            end
        end
    end

`ifdef RUN_CTRL_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST || start_run) begin
            STALLS <= '0;
        end else if (state == RUN && STALL) begin
            STALLS <= sat_inc(STALLS);
        end
    end
`else
    logic unused_stall;
    assign unused_stall = STALL;
    assign STALLS       = '0;
`endif

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of cycle and retire counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4500: RUN-state cycle limit; legal range 1 .. 2^CNT_W-1.
REQ-003 SHALL have parameter RST_CYCLES, default 10: cycles CORE_RST is held high; legal range at least 1.
REQ-004 SHALL have parameter HALT_REPEAT, default 3: consecutive retirements at one PC that mean a self-loop halt; legal range at least 2.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port START, input, 1 bit: level/pulse request to begin a run.
REQ-008 SHALL have port STAT, input, 8 bits: core status; nonzero means core error.
REQ-009 SHALL have port RET_VALID, input, 1 bit: core retired one instruction this cycle.
REQ-010 SHALL have port RET_PC, input, 32 bits: PC of the retired instruction.
REQ-011 SHALL have port STALL, input, 1 bit: core pipeline stalled this cycle.
REQ-012 SHALL have port CORE_RST, output, 1 bit: reset to core.
REQ-013 SHALL have port EXEC, output, 1 bit: core execute enable.
REQ-014 SHALL have port BUSY, output, 1 bit: run in progress.
REQ-015 SHALL have port DONE, output, 1 bit: run finished; RESULT is valid.
REQ-016 SHALL have port RESULT, output, 2 bits: 00 none, 01 halt, 10 timeout, 11 error.
REQ-017 SHALL have port CYCLES, output, CNT_W bits: cycles spent in RUN.
REQ-018 SHALL have port INSTRET, output, CNT_W bits: retired-instruction count.
REQ-019 SHALL have port STALLS, output, CNT_W bits: stalled cycles counted in RUN.

Function
REQ-020 SHALL implement states IDLE, CRST, RUN and FIN.
REQ-021 In IDLE or FIN, START=1 SHALL go to CRST next cycle, clear CYCLES, INSTRET, STALLS, the repeat count and the last-PC register, and set DONE=0 and RESULT=00.
REQ-022 START SHALL be ignored in CRST and RUN.
REQ-023 In CRST, CORE_RST SHALL be 1 for exactly RST_CYCLES cycles and EXEC SHALL be 0; after that the block SHALL go to RUN.
REQ-024 In RUN, EXEC SHALL be 1 and CYCLES SHALL increment every cycle.
REQ-025 BUSY SHALL be 1 in CRST and RUN only.
REQ-026 When RET_VALID=1 in RUN, INSTRET SHALL increment.
REQ-027 When RET_VALID=1 in RUN and RET_PC equals the last retired PC, the repeat count SHALL increment; otherwise it SHALL reset to 1 and the last retired PC SHALL be updated.
REQ-028 The first retirement of a run SHALL never count as a repeat.
REQ-029 RUN SHALL exit to FIN on the first of three conditions: STAT nonzero gives RESULT=11; repeat count reaching HALT_REPEAT gives RESULT=01; CYCLES reaching TIMEOUT_CYCLES gives RESULT=10.
REQ-030 When exit conditions coincide in one cycle, priority SHALL be error, then halt, then timeout.
REQ-031 The exit cycle SHALL itself be counted; counters SHALL freeze in FIN.
REQ-032 FIN SHALL drive DONE=1, EXEC=0 and CORE_RST=0, and SHALL hold RESULT and the counters until the next START.
REQ-033 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-034 RET_VALID, STALL and STAT SHALL be ignored outside RUN.

Reset
REQ-035 RST=1 at any clock edge, including mid-run, SHALL force IDLE, CORE_RST=0, EXEC=0, BUSY=0, DONE=0, RESULT=00, all counters=0, repeat count=0 and last PC=0.

Configuration
REQ-036 Macro RUN_CTRL_PERF_EN SHALL select whether the STALLS counter is built.
REQ-037 With RUN_CTRL_PERF_EN defined, STALLS SHALL count RUN cycles with STALL=1, with the same clear, saturate and freeze rules as the other counters.
REQ-038 Without RUN_CTRL_PERF_EN, STALLS SHALL be constant 0, the STALL input SHALL be unused, and all other behaviour SHALL be unchanged.

Verification
REQ-039 A bench SHALL cover: defaults; START pulse; retire PCs 0,4,8,12,16,16,16 -> CORE_RST high exactly 10 cycles, then DONE=1, RESULT=01, INSTRET=7.
REQ-040 A bench SHALL cover: TIMEOUT_CYCLES=20; no retirements -> DONE=1, RESULT=10, CYCLES=20, EXEC falls the cycle after the 20th RUN cycle.
REQ-041 A bench SHALL cover: STAT=8'h01 asserted in the same cycle as the third repeat of PC 16 -> RESULT=11, because error has priority over halt.
REQ-042 A bench SHALL cover: RST pulse during RUN at CYCLES=50 -> next cycle IDLE, all outputs 0; START again -> a full new run with counters starting from 0.
REQ-043 A bench SHALL cover: RUN_CTRL_PERF_EN defined; STALL high 7 of 30 RUN cycles -> STALLS=7. Macro undefined -> STALLS=0.
REQ-044 A bench SHALL cover: CNT_W=4, TIMEOUT_CYCLES=15, retire every cycle with distinct PCs -> INSTRET=15, RESULT=10, no wrap.
